// File: rtl/regwb_pkg.sv
// Shared widths, FSM state type and queue entry layout for the register-file writeback arbiter.
package regwb_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// Per-requester writeback queue; exposes every slot's valid bit and destination register
// so the top level can flag pending writes to the decode read addresses.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_push,
  input  wb_entry_t                        i_entry,
  input  logic                             i_pop,
  output wb_entry_t                        o_head,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [DEPTH-1:0]                 o_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] o_rd
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = &r_valid;
  assign o_empty  = ~|r_valid;
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Per-slot valid bits double as occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_valid[r_rdPtr] <= 1'b0;
        r_rdPtr          <= r_rdPtr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_entry;
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_valid = r_valid;

  always_comb begin
    o_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_rd[i] = r_mem[i].rd;
    end
  end

endmodule

// File: rtl/regwb_arbiter.sv
// Register-file write-port controller: init sweep after reset, then round-robin ALU/LSU writeback with RAW hazard flags.
// Define REGWB_STATS_EN to add the stat_grants / stat_conflicts saturating counters.
module regwb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int XLEN     = 64,
  parameter int INIT_IDX = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            init_done,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [4:0]      ReadReg1,
  input  logic [4:0]      ReadReg2,
  output logic            hazard1,
  output logic            hazard2,
  output logic            RegWrite,
  output logic [4:0]      WriteReg,
  output logic [XLEN-1:0] WriteData
`ifdef REGWB_STATS_EN
  ,
  output logic [31:0]     stat_grants,
  output logic [31:0]     stat_conflicts
`endif
);

  import regwb_pkg::*;

  localparam int PKG_W = regwb_pkg::XLEN;

  state_t                           r_state;
  state_t                           w_nextState;
  logic [5:0]                       r_idx;
  logic                             r_rrLsu;
  logic                             r_regWrite;
  logic [REG_ADDR_W-1:0]            r_writeReg;
  logic [XLEN-1:0]                  r_writeData;

  wb_entry_t                        w_aluIn;
  wb_entry_t                        w_lsuIn;
  wb_entry_t                        w_aluHead;
  wb_entry_t                        w_lsuHead;
  wb_entry_t                        w_grantEntry;
  logic                             w_aluFull;
  logic                             w_aluEmpty;
  logic                             w_lsuFull;
  logic                             w_lsuEmpty;
  logic [DEPTH-1:0]                 w_aluValidVec;
  logic [DEPTH-1:0]                 w_lsuValidVec;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_aluRdVec;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_lsuRdVec;
  logic                             w_run;
  logic                             w_popAlu;
  logic                             w_popLsu;
  logic                             w_pop;
  logic                             w_both;
  logic                             w_match1;
  logic                             w_match2;

  assign w_run     = (r_state == ST_RUN);
  assign alu_ready = w_run && !w_aluFull;
  assign lsu_ready = w_run && !w_lsuFull;

  always_comb begin
    w_aluIn      = '0;
    w_aluIn.rd   = alu_rd;
    w_aluIn.data = PKG_W'(alu_data);
    w_lsuIn      = '0;
    w_lsuIn.rd   = lsu_rd;
    w_lsuIn.data = PKG_W'(lsu_data);
  end

  regwb_fifo #(.DEPTH(DEPTH)) u_aluQ (
    .clk     (clk),
    .reset   (reset),
    .i_push  (alu_valid && alu_ready),
    .i_entry (w_aluIn),
    .i_pop   (w_popAlu),
    .o_head  (w_aluHead),
    .o_full  (w_aluFull),
    .o_empty (w_aluEmpty),
    .o_valid (w_aluValidVec),
    .o_rd    (w_aluRdVec)
  );

  regwb_fifo #(.DEPTH(DEPTH)) u_lsuQ (
    .clk     (clk),
    .reset   (reset),
    .i_push  (lsu_valid && lsu_ready),
    .i_entry (w_lsuIn),
    .i_pop   (w_popLsu),
    .o_head  (w_lsuHead),
    .o_full  (w_lsuFull),
    .o_empty (w_lsuEmpty),
    .o_valid (w_lsuValidVec),
    .o_rd    (w_lsuRdVec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // r_idx[5] marks the sweep as finished; the extra INIT cycle lets the idx 31 write stand for a full cycle.
  always_comb begin
    w_nextState = r_state;
    w_popAlu    = 1'b0;
    w_popLsu    = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_idx[5]) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!w_aluEmpty && (w_lsuEmpty || !r_rrLsu)) begin
          w_popAlu = 1'b1;
        end else if (!w_lsuEmpty) begin
          w_popLsu = 1'b1;
        end
      end
      default: w_nextState = ST_INIT;
    endcase
  end

  assign w_pop        = w_popAlu || w_popLsu;
  assign w_both       = w_run && !w_aluEmpty && !w_lsuEmpty;
  assign w_grantEntry = w_popLsu ? w_lsuHead : w_aluHead;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_rrLsu     <= 1'b0;
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
    end else if (r_state == ST_INIT) begin
      if (!r_idx[5]) begin
        r_regWrite  <= 1'b1;
        r_writeReg  <= r_idx[4:0];
        r_writeData <= (INIT_IDX != 0) ? XLEN'(r_idx[4:0]) : '0;
        r_idx       <= r_idx + 6'd1;
      end else begin
        r_regWrite <= 1'b0;
      end
    end else begin
      r_regWrite <= w_pop && (w_grantEntry.rd != '0);
      if (w_pop) begin
        r_writeReg  <= w_grantEntry.rd;
        r_writeData <= XLEN'(w_grantEntry.data);
      end
      if (w_both) begin
        r_rrLsu <= ~r_rrLsu;
      end
    end
  end

  // A write is pending while it sits in either queue or is on the port this cycle.
  always_comb begin
    w_match1 = r_regWrite && (r_writeReg == ReadReg1);
    w_match2 = r_regWrite && (r_writeReg == ReadReg2);
    for (int i = 0; i < DEPTH; i++) begin
      w_match1 = w_match1
               || (w_aluValidVec[i] && (w_aluRdVec[i] == ReadReg1))
               || (w_lsuValidVec[i] && (w_lsuRdVec[i] == ReadReg1));
      w_match2 = w_match2
               || (w_aluValidVec[i] && (w_aluRdVec[i] == ReadReg2))
               || (w_lsuValidVec[i] && (w_lsuRdVec[i] == ReadReg2));
    end
  end

  assign hazard1   = !w_run || ((ReadReg1 != '0) && w_match1);
  assign hazard2   = !w_run || ((ReadReg2 != '0) && w_match2);
  assign init_done = w_run;
  assign RegWrite  = r_regWrite;
  assign WriteReg  = r_writeReg;
  assign WriteData = r_writeData;

`ifdef REGWB_STATS_EN
  logic [31:0] r_statGrants;
  logic [31:0] r_statConflicts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_statGrants    <= '0;
      r_statConflicts <= '0;
    end else if (w_run) begin
      if (w_pop && (w_grantEntry.rd != '0) && (r_statGrants != '1)) begin
        r_statGrants <= r_statGrants + 32'd1;
      end
      if (w_both && (r_statConflicts != '1)) begin
        r_statConflicts <= r_statConflicts + 32'd1;
      end
    end
  end

  assign stat_grants    = r_statGrants;
  assign stat_conflicts = r_statConflicts;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed bench for regwb_arbiter: init sweep, single-write latency and hazard window, round-robin order,
// backpressure, x0 suppression and mid-operation reset. Stats counters are checked when REGWB_STATS_EN is defined.
module tb_regwb_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            init_done;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic [4:0]      ReadReg1;
  logic [4:0]      ReadReg2;
  logic            hazard1;
  logic            hazard2;
  logic            RegWrite;
  logic [4:0]      WriteReg;
  logic [XLEN-1:0] WriteData;
`ifdef REGWB_STATS_EN
  logic [31:0]     stat_grants;
  logic [31:0]     stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  logic            logEn = 1'b0;
  logic [4:0]      wrRd[$];
  logic [XLEN-1:0] wrData[$];

  int   aIdx;
  int   lIdx;
  logic aRdy;
  logic lRdy;
  logic sawAluFull;

  logic [4:0]      expRd   [7] = '{5'd11, 5'd21, 5'd12, 5'd22, 5'd13, 5'd23, 5'd14};
  logic [XLEN-1:0] expData [7] = '{64'hB000, 64'hA000, 64'hB001, 64'hA001, 64'hB002, 64'hA002, 64'hB003};

  always #5 clk = ~clk;

  regwb_arbiter #(
    .DEPTH    (2),
    .XLEN     (XLEN),
    .INIT_IDX (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData)
`ifdef REGWB_STATS_EN
    ,
    .stat_grants    (stat_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  // Records every write-port pulse while logging is enabled.
  always @(negedge clk) begin
    if (logEn && RegWrite) begin
      wrRd.push_back(WriteReg);
      wrData.push_back(WriteData);
    end
  end

  task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [XLEN-1:0] aData,
                               input logic lV, input logic [4:0] lRd, input logic [XLEN-1:0] lData);
    alu_valid = aV;
    alu_rd    = aRd;
    alu_data  = aData;
    lsu_valid = lV;
    lsu_rd    = lRd;
    lsu_data  = lData;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkInitSweep(input string phase);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_w%0d", phase, i),
                  {RegWrite, WriteReg, WriteData, init_done, alu_ready, lsu_ready, hazard1, hazard2},
                  {1'b1, 5'(i), 64'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    @(negedge clk);
    checkOutput({phase, "_done"}, {RegWrite, init_done, alu_ready, lsu_ready}, 4'b0111);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #2;
    checkOutput("rst_state",
                {init_done, RegWrite, WriteReg, WriteData, alu_ready, lsu_ready, hazard1, hazard2},
                {1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkInitSweep("init");

    // Single ALU write: latency and hazard window on source 1.
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd6;
    #1 checkOutput("t2_pre_haz", {hazard1, hazard2}, 2'b00);
    applyStimulus(1'b1, 5'd5, 64'hABCD, 1'b0, 5'd0, '0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1 checkOutput("t2_queued", {RegWrite, hazard1, hazard2}, 3'b010);
    @(negedge clk);
    checkOutput("t2_write", {RegWrite, WriteReg, WriteData, hazard1}, {1'b1, 5'd5, 64'hABCD, 1'b1});
    ReadReg2 = 5'd5;
    #1 checkOutput("t2_haz2", hazard2, 1'b1);
    @(negedge clk);
    checkOutput("t2_after", {RegWrite, WriteReg, WriteData, hazard1, hazard2},
                {1'b0, 5'd5, 64'hABCD, 1'b0, 1'b0});

    // Two entries per requester: round-robin order 1, 3, 2, 4.
    ReadReg1 = 5'd4;
    ReadReg2 = 5'd0;
    applyStimulus(1'b1, 5'd1, 64'h11, 1'b1, 5'd3, 64'h33);
    @(negedge clk);
    applyStimulus(1'b1, 5'd2, 64'h22, 1'b1, 5'd4, 64'h44);
    #1 checkOutput("t3_mid", {alu_ready, lsu_ready, hazard1, hazard2}, 4'b1100);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1 checkOutput("t3_w0", {RegWrite, WriteReg, WriteData, hazard1}, {1'b1, 5'd1, 64'h11, 1'b1});
    @(negedge clk);
    checkOutput("t3_w1", {RegWrite, WriteReg, WriteData, hazard1}, {1'b1, 5'd3, 64'h33, 1'b1});
    @(negedge clk);
    checkOutput("t3_w2", {RegWrite, WriteReg, WriteData, hazard1}, {1'b1, 5'd2, 64'h22, 1'b1});
    @(negedge clk);
    checkOutput("t3_w3", {RegWrite, WriteReg, WriteData, hazard1}, {1'b1, 5'd4, 64'h44, 1'b1});
    @(negedge clk);
    checkOutput("t3_idle", {RegWrite, hazard1}, 2'b00);

    // ALU backpressure under contention with a streaming LSU.
    ReadReg1 = 5'd0;
    wrRd.delete();
    wrData.delete();
    logEn = 1'b1;
    aIdx = 0;
    lIdx = 0;
    sawAluFull = 1'b0;
    for (int c = 0; c < 10; c++) begin
      aRdy = alu_ready;
      lRdy = lsu_ready;
      if (aIdx < 3 && !aRdy) sawAluFull = 1'b1;
      applyStimulus(aIdx < 3, 5'(21 + aIdx), 64'hA000 + 64'(aIdx),
                    lIdx < 4, 5'(11 + lIdx), 64'hB000 + 64'(lIdx));
      @(posedge clk);
      if (aIdx < 3 && aRdy) aIdx++;
      if (lIdx < 4 && lRdy) lIdx++;
      @(negedge clk);
    end
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1 logEn = 1'b0;
    checkOutput("t4_alu_full_seen", sawAluFull, 1'b1);
    checkOutput("t4_accepted", {8'(aIdx), 8'(lIdx)}, {8'd3, 8'd4});
    checkOutput("t4_count", 32'(wrRd.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      checkOutput($sformatf("t4_wr%0d", k),
                  (k < wrRd.size()) ? {wrRd[k], wrData[k]} : {5'h1F, 64'hFFFF_FFFF_FFFF_FFFF},
                  {expRd[k], expData[k]});
    end

    // LSU write to x0: popped without a write pulse, no hazard on source 0.
    wrRd.delete();
    wrData.delete();
    logEn = 1'b1;
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd0, 64'hDEAD);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1 checkOutput("t5_queued", {RegWrite, hazard1, hazard2, lsu_ready}, 4'b0001);
    @(negedge clk);
    checkOutput("t5_pop", {RegWrite, hazard1}, 2'b00);
    @(negedge clk);
    #1 logEn = 1'b0;
    checkOutput("t5_no_pulse", 32'(wrRd.size()), 32'd0);

`ifdef REGWB_STATS_EN
    checkOutput("stats_run", {stat_grants, stat_conflicts}, {32'd12, 32'd9});
`endif

    // Reset with two queued writes: they are discarded and the sweep repeats.
    ReadReg1 = 5'd7;
    ReadReg2 = 5'd8;
    applyStimulus(1'b1, 5'd7, 64'h77, 1'b1, 5'd8, 64'h88);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1 checkOutput("t6_queued", {RegWrite, hazard1, hazard2}, 3'b011);
    reset = 1'b0;
    #1 checkOutput("t6_in_reset", {init_done, RegWrite, alu_ready, lsu_ready, hazard1, hazard2}, 6'b000011);
`ifdef REGWB_STATS_EN
    checkOutput("stats_reset", {stat_grants, stat_conflicts}, 64'd0);
`endif
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    repeat (2) @(negedge clk);
    wrRd.delete();
    wrData.delete();
    logEn = 1'b1;
    reset = 1'b1;
    checkInitSweep("reinit");
    repeat (4) @(negedge clk);
    #1 logEn = 1'b0;
    checkOutput("t6_total_writes", 32'(wrRd.size()), 32'd32);
    checkOutput("t6_idle", {RegWrite, init_done}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
